// File: rtl/tns_enc_06_pkg.sv
// Shared TNS constants: bit weights, word widths, range limit and encoder FSM states.
// The TNS decoders import the same package so both ends agree on the weights.
package tns_enc_06_pkg;

  localparam int BLEN02  = 6;
  localparam int CODE_W  = 6;
  localparam int IDX_W   = 3;

  localparam int TNS02_A = 13;
  localparam int TNS02_B = 8;
  localparam int TNS02_C = 5;
  localparam int TNS01_A = 3;
  localparam int TNS01_B = 2;
  localparam int TNS01_C = 1;

  localparam int MAXV = TNS02_A + TNS02_B + TNS02_C + TNS01_A + TNS01_B + TNS01_C;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_DONE = 2'd2
  } tns_state_e;

  // Weight of codeword bit idx (bit 5 is TNS02_A, bit 0 is TNS01_C).
  function automatic logic [BLEN02-1:0] weight_of(input logic [IDX_W-1:0] idx);
    logic [BLEN02-1:0] w;
    case (idx)
      3'd5:    w = BLEN02'(TNS02_A);
      3'd4:    w = BLEN02'(TNS02_B);
      3'd3:    w = BLEN02'(TNS02_C);
      3'd2:    w = BLEN02'(TNS01_A);
      3'd1:    w = BLEN02'(TNS01_B);
      3'd0:    w = BLEN02'(TNS01_C);
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/tns_enc_06_step.sv
// One greedy TNS encoding step: take the weight if the remainder covers it.
// Operands carry one guard bit so the compare/subtract can never wrap.
module tns_enc_step
  import tns_enc_06_pkg::*;
#(
  parameter int DATA_W = BLEN02
) (
  input  logic [DATA_W:0] rem,
  input  logic [DATA_W:0] weight,
  output logic            code_bit,
  output logic [DATA_W:0] rem_next
);

  assign code_bit = (rem >= weight);
  assign rem_next = code_bit ? (rem - weight) : rem;

endmodule

// File: rtl/tns_enc_06.sv
// Sequential TNS encoder: accepts a binary word, resolves one codeword bit per
// cycle MSB-first, then holds the codeword until the consumer takes it.
module tns_enc_06
  import tns_enc_06_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BLEN02-1:0] datain,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CODE_W-1:0] codeout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err
);

  tns_state_e         state, state_next;
  logic [BLEN02:0]    rem_p0;
  logic [CODE_W-1:0]  code_p0;
  logic [IDX_W-1:0]   idx_p0;
  logic               err_p0;

  logic [BLEN02:0]    weight;
  logic               code_bit;
  logic [BLEN02:0]    rem_next;

  assign weight = {1'b0, weight_of(idx_p0)};

  tns_enc_step #(.DATA_W(BLEN02)) u_step (
    .rem      (rem_p0),
    .weight   (weight),
    .code_bit (code_bit),
    .rem_next (rem_next)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (in_valid)          state_next = ST_ENC;
      ST_ENC:  if (idx_p0 == '0)      state_next = ST_DONE;
      ST_DONE: if (out_ready)         state_next = ST_IDLE;
      default:                        state_next = ST_IDLE;
    endcase
  end

  // Datapath registers: load on acceptance, one greedy step per ENC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_p0  <= '0;
      code_p0 <= '0;
      idx_p0  <= '0;
      err_p0  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            rem_p0  <= {1'b0, datain};
            code_p0 <= '0;
            idx_p0  <= IDX_W'(CODE_W - 1);
            err_p0  <= ({1'b0, datain} > (BLEN02+1)'(MAXV));
          end
        end
        ST_ENC: begin
          code_p0[idx_p0] <= code_bit;
          rem_p0          <= rem_next;
          if (idx_p0 != '0) idx_p0 <= idx_p0 - IDX_W'(1);
          else              err_p0 <= err_p0 | (rem_next != '0);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    codeout   = (state == ST_DONE) ? code_p0 : '0;
    err       = (state == ST_DONE) ? err_p0  : 1'b0;
  end

endmodule

// File: tb/tb_tns_enc_06.sv
// Directed bench for tns_enc_06: vector table, full 0..32 sweep, stall, reset
// abort and back-to-back throughput sequences.
module tb_tns_enc_06;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] datain;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] codeout;
  logic       out_valid;
  logic       out_ready;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tns_enc_06 dut (
    .clk       (clk),
    .rst       (rst),
    .datain    (datain),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .codeout   (codeout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err)
  );

  typedef struct {
    logic [5:0] din;
    logic [5:0] code;
    logic       err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic int decode(input logic [5:0] c);
    int w[6] = '{1, 2, 3, 5, 8, 13};
    int s = 0;
    for (int i = 0; i < 6; i++) if (c[i]) s += w[i];
    return s;
  endfunction

  // Present one word, wait for out_valid, then optionally take it.
  task automatic encode(input logic [5:0] d, input bit take,
                        output logic [5:0] c, output logic e, output int lat);
    @(negedge clk);
    datain   = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    datain = 6'h2a;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    c = codeout;
    e = err;
    if (take) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  logic [5:0] c;
  logic       e;
  int         lat;

  initial begin
    vecs[0] = '{6'd0,  6'b000000, 1'b0};
    vecs[1] = '{6'd12, 6'b010101, 1'b0};
    vecs[2] = '{6'd20, 6'b101010, 1'b0};
    vecs[3] = '{6'd32, 6'b111111, 1'b0};
    vecs[4] = '{6'd33, 6'b111111, 1'b1};
    vecs[5] = '{6'd63, 6'b111111, 1'b1};
    vecs[6] = '{6'd1,  6'b000001, 1'b0};
    vecs[7] = '{6'd7,  6'b001010, 1'b0};
    vecs[8] = '{6'd13, 6'b100000, 1'b0};
    vecs[9] = '{6'd26, 6'b111000, 1'b0};

    rst = 1'b1; datain = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_codeout", codeout, 0);
    check("reset_err", err, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      encode(vecs[i].din, 1'b1, c, e, lat);
      check($sformatf("vec%0d_latency", i), lat, 6);
      check($sformatf("vec%0d_code", i), c, vecs[i].code);
      check($sformatf("vec%0d_err", i), e, vecs[i].err);
      check($sformatf("vec%0d_release", i), out_valid, 0);
      check($sformatf("vec%0d_idle", i), in_ready, 1);
    end

    for (int d = 0; d <= 32; d++) begin
      encode(6'(d), 1'b1, c, e, lat);
      check($sformatf("sweep%0d_sum", d), decode(c), d);
      check($sformatf("sweep%0d_err", d), e, 0);
    end

    // Stall in DONE for 5 cycles with in_valid pulses that must be ignored.
    encode(6'd20, 1'b0, c, e, lat);
    check("stall_code0", c, 6'b101010);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      datain = 6'd5;
      in_valid = k[0];
      check($sformatf("stall%0d_valid", k), out_valid, 1);
      check($sformatf("stall%0d_code", k), codeout, 6'b101010);
      check($sformatf("stall%0d_ready", k), in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("stall_release", out_valid, 0);
    repeat (10) begin
      @(negedge clk);
      check("stall_no_ghost", out_valid, 0);
    end

    // Reset during ENC cycle 3 discards the word.
    @(negedge clk);
    datain = 6'd32; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_codeout", codeout, 0);
    begin
      int seen = 0;
      repeat (10) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("abort_no_output", seen, 0);
    end
    encode(6'd12, 1'b1, c, e, lat);
    check("after_abort_code", c, 6'b010101);
    check("after_abort_err", e, 0);
    check("after_abort_lat", lat, 6);

    // Back-to-back: in_valid and out_ready held high.
    begin
      logic [5:0] vals[6] = '{6'd12, 6'd20, 6'd7, 6'd32, 6'd26, 6'd1};
      logic [5:0] exps[6] = '{6'b010101, 6'b101010, 6'b001010, 6'b111111, 6'b111000, 6'b000001};
      int acc = 0, outs = 0, last = 0;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int cyc = 0; cyc < 45; cyc++) begin
        if (cyc > 0) @(negedge clk);
        if (out_valid) begin
          if (outs < 6) check($sformatf("b2b%0d_code", outs), codeout, exps[outs]);
          if (outs > 0) check($sformatf("b2b%0d_spacing", outs), cyc - last, 8);
          last = cyc;
          outs++;
        end
        if (in_ready && acc < 6) begin
          datain = vals[acc];
          acc++;
        end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2b_outputs", outs, 5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
